vppm_window_ctrl: RTL and testbench

//  Sequences the VPPM peak-detect datapath once per symbol. Counts ADC sample strobes
//  and drives the detector's sample count and window/clear/latch controls, decimation

---
 rtl/vppm_pkg.sv | 23 ++
 rtl/vppm_sample_counter.sv | 27 ++
 rtl/vppm_window_ctrl.sv | 132 +++++++++++++
 tb/tb_vppm_window_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vppm_pkg.sv
// Shared VPPM definitions: window FSM states, default geometry, count width.
// Used by the window controller and the peak/decision stages.
package vppm_pkg;

    localparam int VPPM_NBADD     = 8;
    localparam int VPPM_NBITS2    = 12;
    localparam int VPPM_N_DEFAULT = 96;
    localparam int VPPM_CNT_W     = VPPM_NBADD + 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        ACQ   = 2'd2,
        LATCH = 2'd3
    } vppm_state_t;

    function automatic int vppm_sym_len(input int nbits2);
        return 1 << nbits2;
    endfunction

    localparam int VPPM_SYM_LEN = vppm_sym_len(VPPM_NBITS2);

endpackage

// File: rtl/vppm_sample_counter.sv
// Strobe-gated sample counter with synchronous clear; wraps SYM_LEN-1 -> 0 and
// flags the terminal count so the FSM can detect the symbol boundary.
module vppm_sample_counter #(
    parameter int W       = 13,
    parameter int SYM_LEN = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(SYM_LEN - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/vppm_window_ctrl.sv
// Per-symbol sequencer for the VPPM peak detector: guard/acquire/latch windows,
// decimation phase and valid/ready result handshake. Option macro: VPPM_RESYNC_EN.
module vppm_window_ctrl
    import vppm_pkg::*;
#(
    parameter int NBADD  = VPPM_NBADD,
    parameter int NBITS2 = VPPM_NBITS2,
    parameter int N      = VPPM_N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sync_pulse,
    input  logic             sample_stb,
    output logic [NBADD+4:0] count_o,
    output logic             acq_en,
    output logic             acq_phase,
    output logic             peak_clear,
    output logic             peak_latch,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic [7:0]       sym_index,
    output logic             overrun
);

    localparam int                CNT_W   = NBADD + 5;
    localparam int                SYM_LEN = vppm_sym_len(NBITS2);
    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);

    vppm_state_t state;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        cnt_tc;
    logic        resync;

`ifdef VPPM_RESYNC_EN
    assign resync = sync_pulse && (state != IDLE);
`else
    assign resync = 1'b0;
`endif

    // The counter is held at zero outside a running symbol; a resync also
    // swallows any coincident strobe.
    always_comb begin
        cnt_clr = !enable || (state == IDLE) || resync;
        cnt_inc = sample_stb && (state != IDLE);
    end

    vppm_sample_counter #(
        .W       (CNT_W),
        .SYM_LEN (SYM_LEN)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (count_o),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acq_en     <= 1'b0;
            acq_phase  <= 1'b1;
            peak_clear <= 1'b0;
            peak_latch <= 1'b0;
            sym_index  <= '0;
        end else begin
            peak_clear <= 1'b0;
            peak_latch <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                acq_en    <= 1'b0;
                acq_phase <= 1'b1;
            end else if (resync) begin
                state      <= GUARD;
                acq_en     <= 1'b0;
                acq_phase  <= 1'b1;
                peak_clear <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (sync_pulse) begin
                            state      <= GUARD;
                            acq_phase  <= 1'b1;
                            peak_clear <= 1'b1;
                        end
                    end
                    GUARD: begin
                        if (sample_stb && count_o == N_CNT) begin
                            state     <= ACQ;
                            acq_en    <= 1'b1;
                            acq_phase <= 1'b1;
                        end
                    end
                    ACQ: begin
                        if (sample_stb) begin
                            acq_phase <= ~acq_phase;
                            if (cnt_tc) begin
                                state      <= LATCH;
                                acq_en     <= 1'b0;
                                peak_latch <= 1'b1;
                                sym_index  <= sym_index + 8'd1;
                            end
                        end
                    end
                    LATCH: begin
                        state      <= GUARD;
                        peak_clear <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A latch always (re)asserts valid; acceptance only drops it when no new
    // result lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (peak_latch) begin
            sym_valid <= 1'b1;
            if (sym_valid && !sym_ready) overrun <= 1'b1;
        end else if (sym_valid && sym_ready) begin
            sym_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vppm_window_ctrl.sv
// Directed bench for vppm_window_ctrl with SYM_LEN=256, N=16; table of reset and
// symbol-start vectors followed by hand-written multi-symbol sequences.
module tb_vppm_window_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        sync_pulse = 1'b0;
    logic        sample_stb = 1'b0;
    logic        sym_ready = 1'b0;
    logic [12:0] count_o;
    logic        acq_en, acq_phase, peak_clear, peak_latch, sym_valid, overrun;
    logic [7:0]  sym_index;

    int n_chk = 0;
    int n_fail = 0;
    logic saw_latch;

    always #5 clk = ~clk;

    vppm_window_ctrl #(.NBADD(8), .NBITS2(8), .N(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sync_pulse (sync_pulse),
        .sample_stb (sample_stb),
        .count_o    (count_o),
        .acq_en     (acq_en),
        .acq_phase  (acq_phase),
        .peak_clear (peak_clear),
        .peak_latch (peak_latch),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_index  (sym_index),
        .overrun    (overrun)
    );

    typedef struct {
        logic        rst, en, sync, stb;
        logic [12:0] cnt;
        logic        acq, ph, clr, lat, val;
        logic [7:0]  idx;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock with the given inputs; outputs are examined 1 time unit after the edge.
    task automatic cyc(input logic e, input logic s, input logic st);
        enable = e; sync_pulse = s; sample_stb = st;
        @(posedge clk);
        #1;
        sync_pulse = 1'b0; sample_stb = 1'b0;
        if (peak_latch) saw_latch = 1'b1;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1);
    endtask

    vec_t vt[7];

    initial begin
        //            rst   en    sync  stb   cnt  acq   ph    clr   lat   val   idx
        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 13'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 13'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 13'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 13'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 13'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 13'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

        saw_latch = 1'b0;
        #2;
        for (int i = 0; i < 7; i++) begin
            rst = vt[i].rst;
            cyc(vt[i].en, vt[i].sync, vt[i].stb);
            check($sformatf("vec%0d count", i), 32'(count_o), 32'(vt[i].cnt));
            check($sformatf("vec%0d acq_en", i), 32'(acq_en), 32'(vt[i].acq));
            check($sformatf("vec%0d acq_phase", i), 32'(acq_phase), 32'(vt[i].ph));
            check($sformatf("vec%0d peak_clear", i), 32'(peak_clear), 32'(vt[i].clr));
            check($sformatf("vec%0d peak_latch", i), 32'(peak_latch), 32'(vt[i].lat));
            check($sformatf("vec%0d sym_valid", i), 32'(sym_valid), 32'(vt[i].val));
            check($sformatf("vec%0d sym_index", i), 32'(sym_index), 32'(vt[i].idx));
            check($sformatf("vec%0d overrun", i), 32'(overrun), 32'd0);
        end

        // Symbol 1: guard ends at strobe 17, phase toggles per strobe, gaps hold.
        strobes(14);
        check("guard count16", 32'(count_o), 32'd16);
        check("guard acq_en", 32'(acq_en), 32'd0);
        strobes(1);
        check("acq open count", 32'(count_o), 32'd17);
        check("acq open acq_en", 32'(acq_en), 32'd1);
        check("acq open phase", 32'(acq_phase), 32'd1);
        strobes(1);
        check("phase s18", 32'(acq_phase), 32'd0);
        strobes(1);
        check("phase s19", 32'(acq_phase), 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        check("gap count", 32'(count_o), 32'd19);
        check("gap phase", 32'(acq_phase), 32'd1);
        strobes(1);
        check("phase s20", 32'(acq_phase), 32'd0);
        check("count s20", 32'(count_o), 32'd20);
        strobes(235);
        check("count 255", 32'(count_o), 32'd255);
        check("no early latch", 32'(saw_latch), 32'd0);
        strobes(1);
        check("s1 latch", 32'(peak_latch), 32'd1);
        check("s1 wrap count", 32'(count_o), 32'd0);
        check("s1 index", 32'(sym_index), 32'd1);
        check("s1 acq_en off", 32'(acq_en), 32'd0);
        check("s1 valid not yet", 32'(sym_valid), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        check("s1 valid", 32'(sym_valid), 32'd1);
        check("s1 latch done", 32'(peak_latch), 32'd0);
        check("s1 clear after latch", 32'(peak_clear), 32'd1);

        // Symbol 2: acceptance coincides with the latch -> valid held, no overrun.
        strobes(256);
        check("s2 latch", 32'(peak_latch), 32'd1);
        check("s2 index", 32'(sym_index), 32'd2);
        check("s2 valid held", 32'(sym_valid), 32'd1);
        sym_ready = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        sym_ready = 1'b0;
        check("coincident valid", 32'(sym_valid), 32'd1);
        check("coincident overrun", 32'(overrun), 32'd0);

        // Symbol 3: latch while unaccepted -> overrun sticky.
        strobes(256);
        check("s3 latch", 32'(peak_latch), 32'd1);
        check("s3 index", 32'(sym_index), 32'd3);
        cyc(1'b1, 1'b0, 1'b0);
        check("overrun set", 32'(overrun), 32'd1);
        check("overrun valid held", 32'(sym_valid), 32'd1);
        sym_ready = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        sym_ready = 1'b0;
        check("accept valid low", 32'(sym_valid), 32'd0);
        check("overrun sticky", 32'(overrun), 32'd1);

        // Enable drop mid-acquisition, then restart.
        saw_latch = 1'b0;
        strobes(100);
        check("pre-drop count", 32'(count_o), 32'd100);
        cyc(1'b0, 1'b0, 1'b1);
        check("drop count", 32'(count_o), 32'd0);
        check("drop acq_en", 32'(acq_en), 32'd0);
        check("drop phase", 32'(acq_phase), 32'd1);
        cyc(1'b0, 1'b1, 1'b1);
        check("disabled sync count", 32'(count_o), 32'd0);
        check("disabled sync clear", 32'(peak_clear), 32'd0);
        cyc(1'b1, 1'b0, 1'b1);
        check("idle no count", 32'(count_o), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        check("restart clear", 32'(peak_clear), 32'd1);
        strobes(17);
        check("restart acq_en", 32'(acq_en), 32'd1);
        check("restart count", 32'(count_o), 32'd17);
        strobes(238);
        check("drop no latch", 32'(saw_latch), 32'd0);
        check("drop index kept", 32'(sym_index), 32'd3);
        strobes(1);
        check("s4 latch", 32'(peak_latch), 32'd1);
        check("s4 index", 32'(sym_index), 32'd4);
        cyc(1'b1, 1'b0, 1'b0);

        // sync_pulse with a coincident strobe mid-acquisition.
        saw_latch = 1'b0;
        strobes(200);
        check("pre-sync count", 32'(count_o), 32'd200);
        cyc(1'b1, 1'b1, 1'b1);
`ifdef VPPM_RESYNC_EN
        check("resync count", 32'(count_o), 32'd0);
        check("resync clear", 32'(peak_clear), 32'd1);
        check("resync acq_en", 32'(acq_en), 32'd0);
        check("resync phase", 32'(acq_phase), 32'd1);
        strobes(255);
`else
        check("sync ignored count", 32'(count_o), 32'd201);
        check("sync ignored clear", 32'(peak_clear), 32'd0);
        check("sync ignored acq_en", 32'(acq_en), 32'd1);
        strobes(54);
`endif
        check("sync no latch", 32'(saw_latch), 32'd0);
        check("sync index kept", 32'(sym_index), 32'd4);
        strobes(1);
        check("s5 latch", 32'(peak_latch), 32'd1);
        check("s5 index", 32'(sym_index), 32'd5);
        check("s5 count", 32'(count_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
